// File: rtl/conv_pkg.sv
// Shared types, default generators and puncturing helpers for the K=7 convolutional encoder.
package conv_pkg;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'b00,
    RATE_2_3 = 2'b01,
    RATE_3_4 = 2'b10
  } rate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DATA  = 2'b01,
    TAIL  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam int         K_DEF  = 7;
  localparam logic [6:0] G0_DEF = 7'o133;
  localparam logic [6:0] G1_DEF = 7'o171;

  // The reserved code falls back to the unpunctured rate.
  function automatic rate_t decode_rate(input logic [1:0] r);
    case (r)
      2'b01:   return RATE_2_3;
      2'b10:   return RATE_3_4;
      default: return RATE_1_2;
    endcase
  endfunction

  // Returns {emit_a, emit_b} for one encode step.
  function automatic logic [1:0] puncture(input rate_t rate, input logic [1:0] phase);
    case (rate)
      RATE_2_3: return (phase == 2'd0) ? 2'b11 : 2'b10;
      RATE_3_4: begin
        case (phase)
          2'd0:    return 2'b11;
          2'd1:    return 2'b10;
          default: return 2'b01;
        endcase
      end
      default:  return 2'b11;
    endcase
  endfunction

  // Puncture phase wraps after 1, 2 or 3 steps depending on rate.
  function automatic logic [1:0] next_phase(input rate_t rate, input logic [1:0] phase);
    case (rate)
      RATE_2_3: return (phase == 2'd1) ? 2'd0 : 2'd1;
      RATE_3_4: return (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Two-entry coded-bit FIFO: accepts 0..2 bits per cycle, pops one, tags the frame's final bit.
module conv_out_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] push_n,
  input  logic       push_bit0,
  input  logic       push_bit1,
  input  logic       push_last,
  input  logic       pop,
  output logic       head,
  output logic       head_last,
  output logic [1:0] count
);

  logic [1:0] bit_q, bit_d;
  logic [1:0] last_q, last_d;
  logic [1:0] count_q, count_d;
  logic [1:0] level;

  // Pop first, then append pushed bits behind whatever remains; a 2-bit push only occurs into an empty FIFO.
  always_comb begin
    bit_d  = bit_q;
    last_d = last_q;
    level  = count_q;
    if (pop) begin
      bit_d[0]  = bit_q[1];
      last_d[0] = last_q[1];
      level     = count_q - 2'd1;
    end
    if (push_n == 2'd2) begin
      bit_d  = {push_bit1, push_bit0};
      last_d = {push_last, 1'b0};
    end else if (push_n == 2'd1) begin
      if (level == 2'd0) begin
        bit_d[0]  = push_bit0;
        last_d[0] = push_last;
      end else begin
        bit_d[1]  = push_bit0;
        last_d[1] = push_last;
      end
    end
    count_d = level + push_n;
  end

  // Occupancy and last-tags are control state and are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      last_q  <= 2'b00;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  // Payload bits need no reset; they are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    bit_q <= bit_d;
  end

  assign head      = bit_q[0];
  assign head_last = last_q[0];
  assign count     = count_q;

endmodule

// File: rtl/punctured_conv_encoder.sv
// Bit-serial K=7 convolutional encoder with 1/2, 2/3, 3/4 puncturing and automatic tail insertion.
module punctured_conv_encoder
  import conv_pkg::*;
#(
  parameter int           K        = K_DEF,
  parameter logic [K-1:0] G0       = G0_DEF,
  parameter logic [K-1:0] G1       = G1_DEF,
  parameter int           TAIL_LEN = K - 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Rate,
  input  logic       InValid,
  input  logic       Input,
  input  logic       InLast,
  output logic       InReady,
  output logic       OutValid,
  output logic       Output,
  output logic       OutLast,
  input  logic       OutReady,
  output logic       Busy
);

  localparam int TW = $clog2(TAIL_LEN + 1);

  state_t        state_q, state_d;
  rate_t         rate_q, rate_d;
  logic [K-2:0]  sr_q, sr_d;
  logic [1:0]    phase_q, phase_d;
  logic [TW-1:0] tail_q, tail_d;

  logic       fifo_head, fifo_head_last;
  logic [1:0] fifo_cnt;
  logic       buf_ok, in_ready, tail_step, step, final_tail, pop;
  logic       bit_in, code_a, code_b;
  logic [K-1:0] sr_full;
  logic [1:0] pat, push_n;
  logic       push_b0, push_b1;

  // Handshake, encode step and puncture selection for the current cycle.
  always_comb begin
    buf_ok     = (fifo_cnt == 2'd0) | ((fifo_cnt == 2'd1) & OutReady);
    in_ready   = (state_q == DATA) & buf_ok;
    tail_step  = (state_q == TAIL) & buf_ok;
    step       = (in_ready & InValid) | tail_step;
    bit_in     = (state_q == DATA) & Input;
    sr_full    = {bit_in, sr_q};
    code_a     = ^(sr_full & G0);
    code_b     = ^(sr_full & G1);
    pat        = puncture(rate_q, phase_q);
    push_n     = 2'd0;
    push_b0    = 1'b0;
    push_b1    = 1'b0;
    if (step) begin
      case (pat)
        2'b11: begin push_n = 2'd2; push_b0 = code_a; push_b1 = code_b; end
        2'b10: begin push_n = 2'd1; push_b0 = code_a; end
        2'b01: begin push_n = 2'd1; push_b0 = code_b; end
        default: ;
      endcase
    end
    final_tail = tail_step & (tail_q == TW'(TAIL_LEN - 1));
    pop        = OutReady & (fifo_cnt != 2'd0);
  end

  // Frame sequencing and encoder state updates.
  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    sr_d    = sr_q;
    phase_d = phase_q;
    tail_d  = tail_q;
    if (step) begin
      sr_d    = sr_full[K-1:1];
      phase_d = next_phase(rate_q, phase_q);
    end
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = DATA;
          rate_d  = decode_rate(Rate);
          sr_d    = '0;
          phase_d = 2'd0;
          tail_d  = '0;
        end
      end
      DATA: begin
        if (step && InLast) state_d = TAIL;
      end
      TAIL: begin
        if (step) tail_d = tail_q + TW'(1);
        if (final_tail) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && fifo_head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any frame in progress.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      rate_q  <= RATE_1_2;
      sr_q    <= '0;
      phase_q <= 2'd0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      sr_q    <= sr_d;
      phase_q <= phase_d;
      tail_q  <= tail_d;
    end
  end

  conv_out_fifo u_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push_n    (push_n),
    .push_bit0 (push_b0),
    .push_bit1 (push_b1),
    .push_last (final_tail),
    .pop       (pop),
    .head      (fifo_head),
    .head_last (fifo_head_last),
    .count     (fifo_cnt)
  );

  assign InReady  = in_ready;
  assign OutValid = (fifo_cnt != 2'd0);
  assign Output   = OutValid & fifo_head;
  assign OutLast  = OutValid & fifo_head_last;
  assign Busy     = (state_q != IDLE);

endmodule
